fetch_align_queue: RTL and testbench
====================================

FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 Parameter QDEPTH, default 8, is the queue capacity in 16-bit parcels; it SHALL be a power of two and at least 4.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the PC after reset; bits [1:0] SHALL be 0.
REQ-003 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port redirect_valid, input, 1 bit: a branch, jump or mispredict redirect is requested.
REQ-006 Port redirect_pc, input, 32 bits: redirect target; bit 0 is ignored.
REQ-007 Port ic_ren, output, 1 bit: I-cache read request.
REQ-008 Port ic_addr, output, 30 bits: word address of the fetch.
REQ-009 Port ic_stall, input, 1 bit: when high, ic_rdata is not valid this cycle.
REQ-010 Port ic_rdata, input, 32 bits: fetched word in big-endian byte order.
REQ-011 Port inst_valid, output, 1 bit: a complete instruction is at the head of the queue.
REQ-012 Port inst_ready, input, 1 bit: decode accepts the head instruction.
REQ-013 Port inst_data, output, 32 bits: head instruction, uncompressed encoding, not decompressed.
REQ-014 Port inst_pc, output, 32 bits: PC of the head instruction.
REQ-015 Port inst_is_c, output, 1 bit: the head instruction is 16-bit (RVC).

Function
REQ-016 Fetch word accept: a word SHALL be accepted in any cycle with ic_ren=1, ic_stall=0 and redirect_valid=0.
REQ-017 Byte order: an accepted word SHALL be converted as {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}.
REQ-018 Parcel order: the converted word's [15:0] parcel SHALL be the lower address and is queued first.
REQ-019 Fetch request: ic_ren SHALL be 1 only when registered free space >= 2 parcels and redirect_valid=0.
REQ-020 Fetch address: ic_addr SHALL be the fetch word-address register; it SHALL increment by 1, wrapping mod 2^30, on each accepted word.
REQ-021 Misaligned target: when the drop_first flag is set, the next accepted word SHALL push only its upper parcel, which then clears drop_first.
REQ-022 inst_valid SHALL be 1 when either condition holds and redirect_valid=0:
- count >= 1 and head parcel [1:0] != 2'b11; or
- count >= 2.
REQ-023 Compressed head: inst_is_c=1 and inst_data={16'h0000, parcel0}.
REQ-024 32-bit head: inst_is_c=0 and inst_data={parcel1, parcel0}.
REQ-025 Incomplete head: a 32-bit head with count=1 SHALL hold inst_valid=0 until its second parcel arrives; this covers an instruction straddling a word.
REQ-026 Pop: on inst_valid & inst_ready, 1 parcel (RVC) or 2 parcels SHALL be removed.
REQ-027 PC advance: on each pop, inst_pc SHALL advance by 2 (RVC) or 4, wrapping mod 2^32.
REQ-028 Simultaneous push and pop: count_next = count + pushed - popped; pushed is 0, 1 or 2, popped is 0, 1 or 2.
REQ-029 Bounds: count SHALL never exceed QDEPTH or go below 0; read and write pointers SHALL wrap mod QDEPTH.
REQ-030 Redirect priority: redirect_valid has priority over all other events; in that cycle push and pop SHALL be discarded and inst_valid=0.
REQ-031 Redirect next state: the cycle after a redirect:
- count=0;
- fetch address = redirect_pc[31:2];
- inst_pc = {redirect_pc[31:1], 1'b0};
- drop_first = redirect_pc[1].
REQ-032 Back-to-back redirects: the last redirect SHALL win.
REQ-033 Fetch latency: with ic_stall=0 and inst_ready=1, the first inst_valid after a redirect SHALL occur 1 cycle after redirect_valid deasserts.
REQ-034 Stalled fetch: while ic_stall=1, the queue SHALL continue to drain to decode and the fetch address SHALL hold.

Reset
REQ-035 While rst_n=0 at a rising edge, the block SHALL set:
- count=0, pointers=0, drop_first=0;
- fetch address = RESET_PC[31:2];
- inst_pc = RESET_PC.
REQ-036 Outputs during and after reset: inst_valid=0 and ic_ren=0 while in reset; ic_ren=1 in the first cycle after reset release.
REQ-037 Reset mid-operation: reset SHALL discard all queued parcels and any outstanding fetch result, with no partial instruction surviving.

Verification
REQ-038 Aligned 32-bit stream: reset, ic_rdata=32'h13000000 (addi x0 after byte swap) each cycle, inst_ready=1 -> inst_valid every cycle from cycle 1, inst_pc=0,4,8, inst_is_c=0.
REQ-039 Compressed pair: word converts to 32'h0001_0001 (two c.nop) -> two instructions, inst_pc=0 then 2, inst_is_c=1, inst_data=32'h00000001.
REQ-040 Straddle: word0 upper parcel 16'h0093 (low half of a 32-bit instruction), word1 lower parcel 16'h0010 -> inst_valid=0 until word1 is accepted, then inst_data=32'h00100093, inst_pc=2.
REQ-041 Misaligned redirect: redirect_pc=32'h0000_0102 -> ic_addr=30'h40; lower parcel dropped; first inst_pc=32'h102.
REQ-042 Full queue: QDEPTH=8, inst_ready=0 -> ic_ren falls to 0 when count >= 7; count never exceeds 8; raising inst_ready resumes fetch.
REQ-043 Redirect during stall: ic_stall=1 and queue non-empty, pulse redirect_valid -> next cycle count=0; the stale word arriving later at the old address is never pushed.

Source files
------------

// File: rtl/fetch_align_queue.sv
// Fetch alignment queue: accepts 32-bit big-endian I-cache words, splits them
// into 16-bit parcels, and presents whole RVC or 32-bit instructions to decode.
// Redirects flush the queue and restart fetch at the (possibly halfword
// aligned) target.
//
// Handshake: decode takes the head instruction in any cycle where
// inst_valid && inst_ready at the rising edge; inst_valid never depends on
// inst_ready. An I-cache word is consumed in any cycle where ic_ren && !ic_stall.
module fetch_align_queue #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ic_ren,
    output logic [29:0] ic_addr,
    input  logic        ic_stall,
    input  logic [31:0] ic_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    localparam int PW = $clog2(QDEPTH);
    // Fetch only while at least two parcel slots are free.
    localparam logic [PW:0] FETCH_MAX_CNT = (PW+1)'(QDEPTH - 2);

    logic [15:0]   q [QDEPTH];
    logic [PW:0]   count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [29:0]   fetch_addr;
    logic [31:0]   pc;
    logic          drop_first;

    logic [31:0]   conv;
    logic [15:0]   parcel0;
    logic [15:0]   parcel1;
    logic          head_c;
    logic          accept;
    logic          pop;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic          unused_redirect_lsb;

    // Bit 0 of the redirect target carries no information for 16-bit aligned code.
    assign unused_redirect_lsb = redirect_pc[0];

    // Byte swap, head decode, handshakes and push/pop amounts.
    always_comb begin
        conv       = {ic_rdata[7:0], ic_rdata[15:8], ic_rdata[23:16], ic_rdata[31:24]};
        parcel0    = q[rd_ptr];
        parcel1    = q[rd_ptr + PW'(1)];
        head_c     = (parcel0[1:0] != 2'b11);
        ic_ren     = rst_n & ~redirect_valid & (count <= FETCH_MAX_CNT);
        ic_addr    = fetch_addr;
        accept     = ic_ren & ~ic_stall;
        inst_valid = rst_n & ~redirect_valid &
                     (((count != '0) & head_c) | (count >= (PW+1)'(2)));
        inst_is_c  = head_c;
        inst_data  = head_c ? {16'h0000, parcel0} : {parcel1, parcel0};
        inst_pc    = pc;
        pop        = inst_valid & inst_ready;
        push_n     = 2'd0;
        pop_n      = 2'd0;
        if (accept) begin
            push_n = drop_first ? 2'd1 : 2'd2;
        end
        if (pop) begin
            pop_n = head_c ? 2'd1 : 2'd2;
        end
    end

    // Parcel storage; the lower-address parcel goes in first, and only the
    // upper parcel is kept when the fetch target was halfword aligned.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (drop_first) begin
                q[wr_ptr] <= conv[31:16];
            end else begin
                q[wr_ptr]          <= conv[15:0];
                q[wr_ptr + PW'(1)] <= conv[31:16];
            end
        end
    end

    // Occupancy, pointers, fetch address and PC; redirect overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            drop_first <= 1'b0;
            fetch_addr <= RESET_PC[31:2];
            pc         <= RESET_PC;
        end else if (redirect_valid) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            drop_first <= redirect_pc[1];
            fetch_addr <= redirect_pc[31:2];
            pc         <= {redirect_pc[31:1], 1'b0};
        end else begin
            count  <= count + (PW+1)'(push_n) - (PW+1)'(pop_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(push_n);
            if (accept) begin
                fetch_addr <= fetch_addr + 30'd1;
                drop_first <= 1'b0;
            end
            if (pop) begin
                pc <= pc + (head_c ? 32'd2 : 32'd4);
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Bench for fetch_align_queue: a parcel-queue reference model plus a small
// instruction memory answer each cycle; outputs are checked against the model.
module tb_fetch_align_queue;

    localparam int          QDEPTH      = 8;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_ren;
    logic [29:0] ic_addr;
    logic        ic_stall;
    logic [31:0] ic_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    fetch_align_queue #(.QDEPTH(QDEPTH), .RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_ren         (ic_ren),
        .ic_addr        (ic_addr),
        .ic_stall       (ic_stall),
        .ic_rdata       (ic_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_is_c      (inst_is_c)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory holds words already in parcel order (low parcel = lower address).
    logic [31:0] mem [64];

    // Reference model state.
    logic [15:0] exp_q [$];
    logic [29:0] m_faddr;
    logic [31:0] m_pc;
    logic        m_drop;

    int n_vec;
    int n_err;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic st,
                        input logic rdy, input logic rn);
        logic        e_ren;
        logic        e_valid;
        logic        e_c;
        logic [31:0] e_data;
        logic [31:0] w;
        int          sz;
        @(negedge clk);
        rst_n          = rn;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_stall       = st;
        inst_ready     = rdy;
        ic_rdata       = st ? $urandom : bswap(mem[m_faddr[5:0]]);
        #1;
        sz      = exp_q.size();
        e_c     = (sz >= 1) && (exp_q[0][1:0] != 2'b11);
        e_ren   = rn && !rv && (QDEPTH - sz >= 2);
        e_valid = rn && !rv && (sz >= 2 || e_c);
        e_data  = 32'h0;
        if (sz >= 1) e_data = e_c ? {16'h0, exp_q[0]} : {(sz >= 2) ? exp_q[1] : 16'h0, exp_q[0]};
        chk("ic_ren", {31'h0, ic_ren}, {31'h0, e_ren});
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
        if (rn) chk("ic_addr", {2'b0, ic_addr}, {2'b0, m_faddr});
        if (e_valid) begin
            chk("inst_pc", inst_pc, m_pc);
            chk("inst_is_c", {31'h0, inst_is_c}, {31'h0, e_c});
            chk("inst_data", inst_data, e_data);
        end
        if (!rn) begin
            exp_q.delete();
            m_faddr = TB_RESET_PC[31:2];
            m_pc    = TB_RESET_PC;
            m_drop  = 1'b0;
        end else if (rv) begin
            exp_q.delete();
            m_faddr = rpc[31:2];
            m_pc    = {rpc[31:1], 1'b0};
            m_drop  = rpc[1];
        end else begin
            if (e_valid && rdy) begin
                if (e_c) begin
                    void'(exp_q.pop_front());
                    m_pc = m_pc + 32'd2;
                end else begin
                    void'(exp_q.pop_front());
                    void'(exp_q.pop_front());
                    m_pc = m_pc + 32'd4;
                end
            end
            if (e_ren && !st) begin
                w = mem[m_faddr[5:0]];
                if (!m_drop) exp_q.push_back(w[15:0]);
                exp_q.push_back(w[31:16]);
                m_drop  = 1'b0;
                m_faddr = m_faddr + 30'd1;
            end
        end
        if (exp_q.size() > QDEPTH) begin
            n_vec++;
            n_err++;
            $error("FAIL model_bound observed=%0d expected<=%0d", exp_q.size(), QDEPTH);
        end
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
    endtask

    // Directed phases followed by randomized traffic.
    initial begin
        n_vec = 0;
        n_err = 0;
        exp_q.delete();
        m_faddr = TB_RESET_PC[31:2];
        m_pc    = TB_RESET_PC;
        m_drop  = 1'b0;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ic_stall = 1'b0; inst_ready = 1'b0; ic_rdata = 32'h0;
        fill(32'h0000_0013);

        // Reset, then an aligned stream of 32-bit addi instructions.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Two c.nop per word.
        fill(32'h0001_0001);
        step(1, 32'h0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);

        // Instruction straddling a word, with the second word stalled.
        fill(32'h0001_0001);
        mem[0] = 32'h0093_0001;
        mem[1] = 32'h0001_0010;
        step(1, 32'h0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

        // Misaligned redirect target.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        step(1, 32'h0000_0102, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Fill the queue with decode blocked, then resume.
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h0003_0003;
        step(1, 32'h0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Redirect while the cache is stalled with a non-empty queue.
        step(1, 32'h0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h0000_0020, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

        // Address and PC wrap-around from a misaligned target.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        step(1, 32'hFFFF_FFFE, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) != 0);
        end

        // Reset in the middle of traffic leaves nothing behind.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
